// File: rtl/tx_ptp_buf.sv
// tx_ptp_buf: bus-written PTP frame buffer replayed as one XGMII frame per start command.
// Optional macro TX_PAD_EN zero-pads frames shorter than 60 bytes up to 60 bytes.
module tx_ptp_buf #(
    parameter logic [31:0] TX_BUF_BADDR = 32'h2000,
    parameter int          IFG_CYCLES   = 2
) (
    input  logic        tx_clk,
    input  logic        tx_rst_n,
    input  logic [31:0] bus2ip_addr_i,
    input  logic [31:0] bus2ip_data_i,
    input  logic        bus2ip_rd_ce_i,
    input  logic        bus2ip_wr_ce_i,
    output logic [31:0] ip2bus_data_o,
    output logic [63:0] xge_txd_o,
    output logic [7:0]  xge_txc_o
);
`ifdef TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam logic [63:0] IDLE_COL = 64'h0707070707070707;
    localparam logic [63:0] PRE_COL  = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_COL = 64'h07070707070707FD;

    typedef enum logic [2:0] {IDLE, PRE, DATA, TERM, IFG} state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic [8:0]  len_q, len_d;
    logic [8:0]  rem_q, rem_d;
    logic [5:0]  col_q, col_d;
    logic [3:0]  ifg_q, ifg_d;
    logic [15:0] cnt_q, cnt_d;
    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;
    logic [31:0] mem_q [128];

    logic [29:0] waddr;
    logic        aligned, buf_hit, len_hit, ctl_hit, start_ok;
    logic [63:0] col_dat, dat_txd;
    logic [7:0]  dat_txc;

    assign waddr    = bus2ip_addr_i[31:2] - TX_BUF_BADDR[31:2];
    assign aligned  = bus2ip_addr_i[1:0] == 2'b00;
    assign buf_hit  = aligned && waddr < 30'd128;
    assign len_hit  = aligned && waddr == 30'h80;
    assign ctl_hit  = aligned && waddr == 30'h81;
    assign start_ok = bus2ip_wr_ce_i && ctl_hit && bus2ip_data_i[0] && !busy_q && len_q != 9'd0;
    assign col_dat  = {mem_q[{col_q, 1'b1}], mem_q[{col_q, 1'b0}]};

    assign ip2bus_data_o = !bus2ip_rd_ce_i ? 32'h0 :
                           buf_hit ? mem_q[waddr[6:0]] :
                           len_hit ? {23'h0, len_q} :
                           ctl_hit ? {cnt_q, 15'h0, busy_q} : 32'h0;

    assign xge_txd_o = txd_q;
    assign xge_txc_o = txc_q;

    // Lanes at or past the remaining count become TERMINATE then idle fill.
    always_comb begin
        dat_txd = '0;
        dat_txc = '0;
        for (int i = 0; i < 8; i++) begin
            dat_txd[i*8 +: 8] = rem_q > 9'(i) ?
                                ((PAD && {col_q, 3'(i)} >= len_q) ? 8'h00 : col_dat[i*8 +: 8]) :
                                rem_q == 9'(i) ? 8'hFD : 8'h07;
            dat_txc[i] = rem_q <= 9'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        len_d   = (bus2ip_wr_ce_i && len_hit && !busy_q) ? bus2ip_data_i[8:0] : len_q;
        rem_d   = rem_q;
        col_d   = col_q;
        ifg_d   = ifg_q;
        cnt_d   = cnt_q;
        txd_d   = IDLE_COL;
        txc_d   = 8'hFF;
        case (state_q)
            IDLE: if (start_ok) begin
                busy_d  = 1'b1;
                state_d = PRE;
                rem_d   = (PAD && len_q < 9'd60) ? 9'd60 : len_q;
                col_d   = '0;
            end
            PRE: begin
                txd_d   = PRE_COL;
                txc_d   = 8'h01;
                state_d = DATA;
            end
            DATA: begin
                txd_d = dat_txd;
                txc_d = dat_txc;
                col_d = col_q + 6'd1;
                rem_d = rem_q - 9'd8;
                if (rem_q == 9'd8) begin
                    state_d = TERM;
                end else if (rem_q < 9'd8) begin
                    cnt_d   = cnt_q + 16'd1;
                    ifg_d   = '0;
                    state_d = IFG;
                end
            end
            TERM: begin
                txd_d   = TERM_COL;
                cnt_d   = cnt_q + 16'd1;
                ifg_d   = '0;
                state_d = IFG;
            end
            IFG: begin
                ifg_d = ifg_q + 4'd1;
                if (ifg_q == 4'(IFG_CYCLES - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            len_q   <= '0;
            rem_q   <= '0;
            col_q   <= '0;
            ifg_q   <= '0;
            cnt_q   <= '0;
            txd_q   <= IDLE_COL;
            txc_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            col_q   <= col_d;
            ifg_q   <= ifg_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            txc_q   <= txc_d;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (bus2ip_wr_ce_i && buf_hit && !busy_q) mem_q[waddr[6:0]] <= bus2ip_data_i;
    end
endmodule
